magnitude_max_tracker: RTL and testbench

MAGNITUDE_MAX_TRACKER -- requirements
Module: magnitude_max_tracker

---
 rtl/magnitude_pkg.sv | 28 ++
 rtl/magnitude_comparator_tree.sv | 31 +++
 rtl/magnitude_max_tracker.sv | 157 +++++++++++++++
 tb/tb_magnitude_max_tracker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/magnitude_pkg.sv
// Shared types for the magnitude max tracker: FSM state and frame result payload.
// MAGNITUDE_MAX_TRACKER_MIN_EN adds the frame-minimum fields to the result.
package magnitude_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    ACC   = 1'b1
  } state_e;

  // Fields are sized for the widest supported configuration; the module narrows them.
  localparam int unsigned RES_DAT_W = 32;
  localparam int unsigned RES_IDX_W = 32;

`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
  typedef struct packed {
    logic [RES_DAT_W-1:0] max;
    logic [RES_IDX_W-1:0] idx;
    logic [RES_DAT_W-1:0] min;
    logic [RES_IDX_W-1:0] min_idx;
  } result_t;
`else
  typedef struct packed {
    logic [RES_DAT_W-1:0] max;
    logic [RES_IDX_W-1:0] idx;
  } result_t;
`endif

endpackage

// File: rtl/magnitude_comparator_tree.sv
// Unsigned a > b compare, resolved per SPLIT segments with the most significant differing segment deciding.
module magnitude_comparator_tree #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SPLIT = 2
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_a
);

  localparam int unsigned NSEG = (SPLIT < 1) ? 1 : SPLIT;
  localparam int unsigned CW   = (WIDTH + NSEG - 1) / NSEG;
  localparam int unsigned PW   = CW * NSEG;

  logic [PW-1:0] a_p;
  logic [PW-1:0] b_p;

  assign a_p = PW'(i_a);
  assign b_p = PW'(i_b);

  // Later (more significant) differing segments override earlier verdicts.
  always_comb begin
    o_a = 1'b0;
    for (int unsigned s = 0; s < NSEG; s++) begin
      if (a_p[s*CW +: CW] != b_p[s*CW +: CW]) begin
        o_a = (a_p[s*CW +: CW] > b_p[s*CW +: CW]);
      end
    end
  end

endmodule

// File: rtl/magnitude_max_tracker.sv
// Streams framed unsigned samples and reports each frame's maximum and its first beat index.
// MAGNITUDE_MAX_TRACKER_MIN_EN additionally reports the frame minimum and its first index.
module magnitude_max_tracker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SPLIT = 2,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_lst,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_max,
  output logic [IDX_W-1:0] o_idx
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
  ,
  output logic [WIDTH-1:0] o_min,
  output logic [IDX_W-1:0] o_min_idx
`endif
);

  import magnitude_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             vld_d;
  result_t          res_d;
  logic             accept;
  logic             first_beat;
  logic             gt_max;
  logic [WIDTH-1:0] upd_max;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_res;

  assign o_rdy      = !o_vld || i_rdy;
  assign accept     = i_vld && o_rdy;
  assign first_beat = (state_q == EMPTY);
  assign unused_res = ^res_d;

  magnitude_comparator_tree #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_cmp_max (
    .i_a (i_dat),
    .i_b (run_max_q),
    .o_a (gt_max)
  );

  assign upd_max = (first_beat || gt_max) ? i_dat : run_max_q;
  assign upd_idx = first_beat ? '0 : (gt_max ? cnt_q : run_idx_q);

`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [IDX_W-1:0] run_min_idx_q, run_min_idx_d;
  logic             lt_min;
  logic [WIDTH-1:0] upd_min;
  logic [IDX_W-1:0] upd_min_idx;

  magnitude_comparator_tree #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_cmp_min (
    .i_a (run_min_q),
    .i_b (i_dat),
    .o_a (lt_min)
  );

  assign upd_min     = (first_beat || lt_min) ? i_dat : run_min_q;
  assign upd_min_idx = first_beat ? '0 : (lt_min ? cnt_q : run_min_idx_q);
`endif

  // Next-state and result capture.
  always_comb begin
    state_d     = state_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    cnt_d       = cnt_q;
    vld_d       = o_vld;
    res_d       = '0;
    res_d.max   = RES_DAT_W'(o_max);
    res_d.idx   = RES_IDX_W'(o_idx);
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
    run_min_d     = run_min_q;
    run_min_idx_d = run_min_idx_q;
    res_d.min     = RES_DAT_W'(o_min);
    res_d.min_idx = RES_IDX_W'(o_min_idx);
`endif

    if (o_vld && i_rdy) begin
      vld_d = 1'b0;
    end

    if (accept) begin
      run_max_d = upd_max;
      run_idx_d = upd_idx;
      cnt_d     = first_beat ? IDX_W'(1) : cnt_q + IDX_W'(1);
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
      run_min_d     = upd_min;
      run_min_idx_d = upd_min_idx;
`endif
      if (i_lst) begin
        state_d   = EMPTY;
        vld_d     = 1'b1;
        res_d.max = RES_DAT_W'(upd_max);
        res_d.idx = RES_IDX_W'(upd_idx);
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
        res_d.min     = RES_DAT_W'(upd_min);
        res_d.min_idx = RES_IDX_W'(upd_min_idx);
`endif
      end else begin
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      run_max_q <= '0;
      run_idx_q <= '0;
      cnt_q     <= '0;
      o_vld     <= 1'b0;
      o_max     <= '0;
      o_idx     <= '0;
    end else begin
      state_q   <= state_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      cnt_q     <= cnt_d;
      o_vld     <= vld_d;
      o_max     <= res_d.max[WIDTH-1:0];
      o_idx     <= res_d.idx[IDX_W-1:0];
    end
  end

`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min_q     <= '0;
      run_min_idx_q <= '0;
      o_min         <= '0;
      o_min_idx     <= '0;
    end else begin
      run_min_q     <= run_min_d;
      run_min_idx_q <= run_min_idx_d;
      o_min         <= res_d.min[WIDTH-1:0];
      o_min_idx     <= res_d.min_idx[IDX_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_magnitude_max_tracker.sv
// Self-checking bench for magnitude_max_tracker: frame-level model plus directed literal checks.
module tb_magnitude_max_tracker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned SPLIT = 2;
  localparam int unsigned IDX_W = 8;

  logic             clk;
  logic             rst_n;
  logic             i_vld;
  logic             o_rdy;
  logic [WIDTH-1:0] i_dat;
  logic             i_lst;
  logic             o_vld;
  logic             i_rdy;
  logic [WIDTH-1:0] o_max;
  logic [IDX_W-1:0] o_idx;
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
  logic [WIDTH-1:0] o_min;
  logic [IDX_W-1:0] o_min_idx;
`endif

  magnitude_max_tracker #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .i_dat     (i_dat),
    .i_lst     (i_lst),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_max     (o_max),
    .o_idx     (o_idx)
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
    ,
    .o_min     (o_min),
    .o_min_idx (o_min_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } lit_t;
  lit_t lit_q[$];

  // Frame-level model: collect accepted samples, evaluate the whole frame on its last beat.
  int   frame_q[$];
  logic m_vld     = 1'b0;
  int   m_max     = 0;
  int   m_idx     = 0;
  int   m_min     = 0;
  int   m_min_idx = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q.delete();
      m_vld     <= 1'b0;
      m_max     <= 0;
      m_idx     <= 0;
      m_min     <= 0;
      m_min_idx <= 0;
    end else begin
      if (m_vld && i_rdy) m_vld <= 1'b0;
      if (i_vld && (!m_vld || i_rdy)) begin
        frame_q.push_back(int'(i_dat));
        if (i_lst) begin
          int bmax, bidx, bmin, bmidx;
          bmax = frame_q[0]; bidx = 0; bmin = frame_q[0]; bmidx = 0;
          for (int k = 1; k < frame_q.size(); k++) begin
            if (frame_q[k] > bmax) begin bmax = frame_q[k]; bidx = k; end
            if (frame_q[k] < bmin) begin bmin = frame_q[k]; bmidx = k; end
          end
          m_vld     <= 1'b1;
          m_max     <= bmax;
          m_idx     <= bidx % (1 << IDX_W);
          m_min     <= bmin;
          m_min_idx <= bmidx % (1 << IDX_W);
          frame_q.delete();
        end
      end
    end
  end

  function automatic int got_of(input int sel);
    case (sel)
      0: return int'(o_vld);
      1: return int'(o_max);
      2: return int'(o_idx);
      3: return int'(o_rdy);
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
      4: return int'(o_min);
      5: return int'(o_min_idx);
`endif
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Single compare process: model check every cycle, then any queued literal expectations.
  always @(negedge clk) begin
    chk("vld_model", int'(o_vld), int'(m_vld));
    chk("rdy_model", int'(o_rdy), int'(!m_vld || i_rdy));
    if (m_vld && rst_n) begin
      chk("max_model", int'(o_max), m_max);
      chk("idx_model", int'(o_idx), m_idx);
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
      chk("min_model", int'(o_min), m_min);
      chk("min_idx_model", int'(o_min_idx), m_min_idx);
`endif
    end
    while (lit_q.size() > 0) begin
      lit_t l;
      l = lit_q.pop_front();
      chk(l.name, got_of(l.sel), l.exp);
    end
  end

  task automatic lit(input string name, input int sel, input int exp);
    lit_t l;
    l.name = name; l.sel = sel; l.exp = exp;
    lit_q.push_back(l);
  endtask

  task automatic expect_res(input string name, input int mx, input int ix);
    lit({name, "_vld"}, 0, 1);
    lit({name, "_max"}, 1, mx);
    lit({name, "_idx"}, 2, ix);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic beat(input int d, input bit l);
    bit acc;
    acc   = 1'b0;
    i_vld = 1'b1;
    i_dat = WIDTH'(d);
    i_lst = l;
    for (int n = 0; n < 20 && !acc; n++) begin
      #2;
      acc = o_rdy;
      @(posedge clk); #1;
    end
    i_vld = 1'b0;
    i_lst = 1'b0;
    if (!acc) lit("beat_timeout", 99, 1);
  endtask

  task automatic drain();
    i_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_vld = 1'b0;
    i_dat = '0;
    i_lst = 1'b0;
    i_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("rst_vld", 0, 0);
    lit("rst_max", 1, 0);
    lit("rst_idx", 2, 0);
    lit("rst_rdy", 3, 1);
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
    lit("rst_min", 4, 0);
    lit("rst_min_idx", 5, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie on 9 keeps the earlier index.
    beat(3, 0); beat(9, 0); beat(2, 0); beat(9, 1);
    expect_res("f1", 9, 1);
    drain();

    // Single-beat frame then an immediate two-beat frame.
    beat(5, 1);
    expect_res("f2a", 5, 0);
    lit("f2a_rdy", 3, 1);
    beat(0, 0);
    lit("f2b_rdy", 3, 1);
    beat(0, 1);
    expect_res("f2c", 0, 0);
    lit("f2c_rdy", 3, 1);
    drain();

    // Back-pressure: result held, next frame stalled, then transfer plus new result together.
    i_rdy = 1'b0;
    beat(1, 0); beat(15, 1);
    expect_res("f3", 15, 1);
    i_vld = 1'b1; i_dat = WIDTH'(4); i_lst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      lit("f3_hold_rdy", 3, 0);
      expect_res("f3_hold", 15, 1);
      @(posedge clk); #1;
    end
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_vld = 1'b0; i_lst = 1'b0;
    expect_res("f4", 4, 0);
    drain();

    // Reset mid-frame discards the open frame.
    beat(7, 0); beat(8, 0);
    rst_n = 1'b0;
    lit("mid_rst_vld", 0, 0);
    lit("mid_rst_max", 1, 0);
    lit("mid_rst_rdy", 3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(2, 1);
    expect_res("f5", 2, 0);
    drain();

    // 257 beats: the index counter wraps so beat 256 reports index 0.
    for (int n = 0; n < 256; n++) beat(0, 0);
    beat(6, 1);
    expect_res("f6_wrap", 6, 0);
    drain();

    // Early maximum with later ties and smaller values.
    beat(7, 0); beat(7, 0); beat(3, 0); beat(7, 1);
    expect_res("f7", 7, 0);
    drain();
    beat(15, 0); beat(15, 1);
    expect_res("f8", 15, 0);
    drain();

`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
    beat(8, 0); beat(3, 0); beat(12, 0); beat(3, 1);
    expect_res("f9", 12, 2);
    lit("f9_min", 4, 3);
    lit("f9_min_idx", 5, 1);
    drain();
`endif

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
